// File: rtl/m_uart_pkg.sv
// rtl/m_uart_pkg.sv - shared encodings and baud divider helper for the oversampling UART receiver
package m_uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_START  = 3'b001;
    localparam logic [2:0] ST_DATA   = 3'b010;
    localparam logic [2:0] ST_PARITY = 3'b011;
    localparam logic [2:0] ST_STOP   = 3'b100;

    localparam int PAR_MODE_EVEN = 0;
    localparam int PAR_MODE_ODD  = 1;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/m_uart_rx_fifo.sv
// rtl/m_uart_rx_fifo.sv - synchronous receive FIFO with show-ahead head output
module m_uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        // Extra pointer bit distinguishes full from empty when the indices match.
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count    = wr_ptr_q - rd_ptr_q;
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/m_uart_rx_os.sv
// rtl/m_uart_rx_os.sv - oversampling UART receiver with majority vote, receive FIFO and sticky errors
module m_uart_rx_os
    import m_uart_pkg::*;
#(
    parameter int WORD       = 8,
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RXD,
    input  logic                          read,
    input  logic                          err_clr,
    output logic [WORD-1:0]               data_o,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    state,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);

    localparam logic [PW-1:0] P_LAST    = PW'(DIV - 1);
    localparam logic [TW-1:0] T_S0      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1      = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC     = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END     = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    B_LASTDAT = 4'(WORD - 1);
    localparam logic [3:0]    B_LASTSTP = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD == PAR_MODE_ODD);

    logic            rxd_s1_q, rxd_s2_q;
    logic [2:0]      state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [WORD-1:0] shreg_q, shreg_d;
    logic            smp0_q, smp0_d;
    logic            smp1_q, smp1_d;
    logic            par_bad_q, par_bad_d;
    logic            stop_bad_q, stop_bad_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;
    logic            overrun_q, overrun_d;

    logic            rx, tick, dec, bit_end, maj, stop_bad_now;
    logic            frame_done, frame_set, parity_set, good_push;
    logic            fifo_push, fifo_full, fifo_empty;

    always_comb begin
        rx           = rxd_s2_q;
        tick         = (state_q != ST_IDLE) && (presc_q == P_LAST);
        dec          = tick && (tcnt_q == T_DEC);
        bit_end      = tick && (tcnt_q == T_END);
        maj          = (smp0_q & smp1_q) | (smp0_q & rx) | (smp1_q & rx);
        stop_bad_now = stop_bad_q | ~maj;

        state_d    = state_q;
        presc_d    = (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
        tcnt_d     = tcnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        smp0_d     = smp0_q;
        smp1_d     = smp1_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        frame_done = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;

        if (tick) begin
            tcnt_d = (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;
            if (tcnt_q == T_S0) smp0_d = rx;
            if (tcnt_q == T_S1) smp1_d = rx;
        end

        case (state_q)
            ST_IDLE: begin
                presc_d    = '0;
                tcnt_d     = '0;
                bit_d      = '0;
                par_bad_d  = 1'b0;
                stop_bad_d = 1'b0;
                if (!rx) state_d = ST_START;
            end
            ST_START: begin
                if (dec && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (dec) shreg_d = {maj, shreg_q[WORD-1:1]};
                if (bit_end) begin
                    if (bit_q == B_LASTDAT) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (dec && (maj != (^shreg_q ^ PAR_ODD))) par_bad_d = 1'b1;
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                // Leave at the decision tick of the last stop bit so a following start edge is caught.
                if (dec) begin
                    if (bit_q == B_LASTSTP) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                        frame_set  = stop_bad_now;
                        parity_set = par_bad_q;
                    end else begin
                        stop_bad_d = stop_bad_now;
                    end
                end
                if (bit_end) bit_d = bit_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        good_push    = frame_done && !frame_set && !parity_set;
        fifo_push    = good_push;
        frame_err_d  = frame_set  | (frame_err_q  & ~err_clr);
        parity_err_d = parity_set | (parity_err_q & ~err_clr);
        overrun_d    = (good_push && fifo_full && !read) | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_s1_q     <= 1'b1;
            rxd_s2_q     <= 1'b1;
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            tcnt_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            smp0_q       <= 1'b1;
            smp1_q       <= 1'b1;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rxd_s1_q     <= RXD;
            rxd_s2_q     <= rxd_s1_q;
            state_q      <= state_d;
            presc_q      <= presc_d;
            tcnt_q       <= tcnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            smp0_q       <= smp0_d;
            smp1_q       <= smp1_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    m_uart_rx_fifo #(
        .WIDTH (WORD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (shreg_q),
        .pop   (read),
        .dout  (data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign valid      = !fifo_empty;
    assign state      = state_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_m_uart_rx_os.sv
// tb/tb_m_uart_rx_os.sv - directed bench for m_uart_rx_os (8N1 instance and 8E1 instance)
module tb_m_uart_rx_os;

    localparam int BIT = 144;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd0 = 1'b1, rxd1 = 1'b1;
    logic       read0 = 1'b0, read1 = 1'b0;
    logic       clr0 = 1'b0, clr1 = 1'b0;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic [2:0] cnt0, cnt1;
    logic [2:0] st0, st1;
    logic       fe0, fe1, pe0, pe1, ov0, ov1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    m_uart_rx_os dut0 (
        .clk(clk), .reset(reset), .RXD(rxd0), .read(read0), .err_clr(clr0),
        .data_o(data0), .valid(valid0), .fifo_count(cnt0), .state(st0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    m_uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .RXD(rxd1), .read(read1), .err_clr(clr1),
        .data_o(data1), .valid(valid1), .fifo_count(cnt1), .state(st1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    task automatic line_bit(input int sel, input logic b);
        if (sel == 0) rxd0 = b; else rxd1 = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        line_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) line_bit(sel, d[i]);
        if (use_par) line_bit(sel, par_bit);
        line_bit(sel, stop_bit);
        if (sel == 0) rxd0 = 1'b1; else rxd1 = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop0;
        read0 = 1'b1;
        @(negedge clk);
        read0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr(input int sel);
        if (sel == 0) clr0 = 1'b1; else clr1 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        clr1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        idle(3);
        compared++; if (st0 !== 3'b000) begin mismatched++; $display("FAIL reset_state got %b want 000", st0); end
        compared++; if (valid0 !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", valid0); end
        compared++; if (cnt0 !== 3'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", cnt0); end
        compared++; if (data0 !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", data0); end
        compared++; if ({fe0, pe0, ov0} !== 3'b000) begin mismatched++; $display("FAIL reset_flags got %b want 000", {fe0, pe0, ov0}); end
        reset = 1'b1;
        idle(20);
    endtask

    task automatic test_basic;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(20);
        compared++; if (data0 !== 8'hA5) begin mismatched++; $display("FAIL basic_data got %h want a5", data0); end
        compared++; if (valid0 !== 1'b1) begin mismatched++; $display("FAIL basic_valid got %b want 1", valid0); end
        compared++; if (cnt0 !== 3'd1) begin mismatched++; $display("FAIL basic_count got %0d want 1", cnt0); end
        compared++; if ({fe0, pe0, ov0} !== 3'b000) begin mismatched++; $display("FAIL basic_flags got %b want 000", {fe0, pe0, ov0}); end
        pop0;
        compared++; if (valid0 !== 1'b0) begin mismatched++; $display("FAIL basic_pop_valid got %b want 0", valid0); end
        compared++; if (data0 !== 8'h00) begin mismatched++; $display("FAIL basic_pop_data got %h want 00", data0); end
    endtask

    task automatic test_false_start;
        rxd0 = 1'b0;
        idle(40);
        rxd0 = 1'b1;
        idle(300);
        compared++; if (st0 !== 3'b000) begin mismatched++; $display("FAIL false_state got %b want 000", st0); end
        compared++; if (cnt0 !== 3'd0) begin mismatched++; $display("FAIL false_count got %0d want 0", cnt0); end
        compared++; if ({fe0, pe0, ov0} !== 3'b000) begin mismatched++; $display("FAIL false_flags got %b want 000", {fe0, pe0, ov0}); end
    endtask

    task automatic test_frame_err;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(400);
        compared++; if (fe0 !== 1'b1) begin mismatched++; $display("FAIL ferr_set got %b want 1", fe0); end
        compared++; if (cnt0 !== 3'd0) begin mismatched++; $display("FAIL ferr_count got %0d want 0", cnt0); end
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        idle(20);
        compared++; if (cnt0 !== 3'd1) begin mismatched++; $display("FAIL ferr_next_count got %0d want 1", cnt0); end
        compared++; if (data0 !== 8'h12) begin mismatched++; $display("FAIL ferr_next_data got %h want 12", data0); end
        compared++; if (fe0 !== 1'b1) begin mismatched++; $display("FAIL ferr_sticky got %b want 1", fe0); end
        pop0;
        pulse_clr(0);
        compared++; if (fe0 !== 1'b0) begin mismatched++; $display("FAIL ferr_clr got %b want 0", fe0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
        idle(20);
        compared++; if (cnt0 !== 3'd4) begin mismatched++; $display("FAIL b2b_count got %0d want 4", cnt0); end
        compared++; if (ov0 !== 1'b1) begin mismatched++; $display("FAIL b2b_overrun got %b want 1", ov0); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            compared++; if (data0 !== exp) begin mismatched++; $display("FAIL b2b_read%0d got %h want %h", i, data0, exp); end
            pop0;
        end
        compared++; if (valid0 !== 1'b0) begin mismatched++; $display("FAIL b2b_drain got %b want 0", valid0); end
        pulse_clr(0);
        compared++; if (ov0 !== 1'b0) begin mismatched++; $display("FAIL b2b_ovr_clr got %b want 0", ov0); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'hC3;
        line_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) line_bit(0, d[i]);
        rxd0 = d[3];
        idle(72);
        reset = 1'b0;
        idle(2);
        compared++; if (st0 !== 3'b000) begin mismatched++; $display("FAIL rmid_state got %b want 000", st0); end
        compared++; if (cnt0 !== 3'd0) begin mismatched++; $display("FAIL rmid_count got %0d want 0", cnt0); end
        compared++; if ({fe0, pe0, ov0} !== 3'b000) begin mismatched++; $display("FAIL rmid_flags got %b want 000", {fe0, pe0, ov0}); end
        rxd0 = 1'b1;
        idle(5);
        reset = 1'b1;
        idle(50);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(20);
        compared++; if (data0 !== 8'h3C) begin mismatched++; $display("FAIL rmid_next_data got %h want 3c", data0); end
        compared++; if (cnt0 !== 3'd1) begin mismatched++; $display("FAIL rmid_next_count got %0d want 1", cnt0); end
    endtask

    task automatic test_parity;
        send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1);
        idle(20);
        compared++; if (pe1 !== 1'b1) begin mismatched++; $display("FAIL par_err got %b want 1", pe1); end
        compared++; if (cnt1 !== 3'd0) begin mismatched++; $display("FAIL par_count got %0d want 0", cnt1); end
        pulse_clr(1);
        compared++; if (pe1 !== 1'b0) begin mismatched++; $display("FAIL par_clr got %b want 0", pe1); end
        send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1);
        idle(20);
        compared++; if (data1 !== 8'h37) begin mismatched++; $display("FAIL par_good_data got %h want 37", data1); end
        compared++; if (pe1 !== 1'b0) begin mismatched++; $display("FAIL par_good_flag got %b want 0", pe1); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_false_start;
        test_frame_err;
        test_back_to_back;
        test_reset_mid;
        test_parity;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
